// File: rtl/rotator_arbiter_pkg.sv
// Shared widths and the left-to-right rotate amount conversion used by the
// rotator arbiter and its barrel rotator.
package rotator_arbiter_pkg;

    localparam int ROT_W  = 3;
    localparam int DATA_W = 8;

    // A left rotate by n is a right rotate by the 3-bit negation of n.
    function automatic logic [ROT_W-1:0] eff_amt(input logic [ROT_W-1:0] amt,
                                                 input logic             left);
        logic [ROT_W-1:0] neg;
        neg = '0 - amt;
        return left ? neg : amt;
    endfunction

endpackage

// File: rtl/ror8.sv
// Purely combinational 8-bit right rotator, three mux stages of 4, 2 and 1.
module ror8
    import rotator_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic [ROT_W-1:0]  amt,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] stage4;
    logic [DATA_W-1:0] stage2;

    assign stage4 = amt[2] ? {din[3:0], din[7:4]}       : din;
    assign stage2 = amt[1] ? {stage4[1:0], stage4[7:2]} : stage4;
    assign dout   = amt[0] ? {stage2[0], stage2[7:1]}   : stage2;

endmodule

// File: rtl/rotator_arbiter.sv
// Round-robin arbiter sharing one 8-bit barrel rotator between NUM_REQ
// requesters, with a single backpressured output register.
module rotator_arbiter
    import rotator_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*ROT_W-1:0]  req_amt,
    input  logic [NUM_REQ-1:0]        req_left,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    output logic [ROT_W-1:0]          out_amt
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   next_ptr;
    logic [ID_W:0]     cand;
    logic              gnt_found;
    logic              load_en;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] rot_data;
    logic [ROT_W-1:0]  sel_amt;
    logic [ROT_W-1:0]  eff_k;
    logic              sel_left;

    assign load_en = !out_valid || out_ready;

    // Scan from ptr upward; cand is one bit wider so ptr+offset never
    // overflows before the modulo wrap for non-power-of-two counts.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        req_ready = '0;
        if (load_en) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                cand = {1'b0, ptr} + (ID_W+1)'(off);
                if (cand >= NUM_REQ_W) begin
                    cand = cand - NUM_REQ_W;
                end
                if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_id    = cand[ID_W-1:0];
                end
            end
        end
        if (gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        sel_amt  = '0;
        sel_left = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_amt  = req_amt[i*ROT_W +: ROT_W];
                sel_left = req_left[i];
            end
        end
    end

    assign eff_k    = eff_amt(sel_amt, sel_left);
    assign next_ptr = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);

    ror8 u_ror8 (
        .din  (sel_data),
        .amt  (eff_k),
        .dout (rot_data)
    );

    // A new grant always wins over a plain drain, giving bubble-free refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_amt   <= '0;
        end else if (gnt_found) begin
            ptr       <= next_ptr;
            out_valid <= 1'b1;
            out_data  <= rot_data;
            out_id    <= gnt_id;
            out_amt   <= eff_k;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rotator_arbiter.sv
// Bench for rotator_arbiter: directed vector table, reset sequences and
// randomized traffic compared against a behavioural model.
module tb_rotator_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*8-1:0] req_data;
    logic [N*3-1:0] req_amt;
    logic [N-1:0]  req_left;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [1:0]    out_id;
    logic [2:0]    out_amt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: what the output register and pointer should hold.
    int m_valid, m_data, m_id, m_amt, m_ptr;
    logic [N-1:0] m_ready;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [11:0] amt;
        logic [3:0]  left;
        logic        oready;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_id;
        logic [2:0]  exp_amt;
    } vec_t;

    vec_t vecs[19];

    rotator_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_left  (req_left),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_amt   (out_amt)
    );

    always #5 clk = ~clk;

    function automatic int rot_ref(int d, int k);
        return ((d >> k) | (d << (8 - k))) & 255;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_id = 0; m_amt = 0; m_ptr = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Called just after a rising edge; samples req_ready mid-cycle, then
    // advances one edge and updates the model.
    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d,
                                 input logic [11:0] a, input logic [3:0] l,
                                 input logic orr, output logic [3:0] seen_ready);
        int g;
        int amt, k;
        req_valid = v; req_data = d; req_amt = a; req_left = l; out_ready = orr;
        #4;
        seen_ready = req_ready;
        g = -1;
        if (m_valid == 0 || orr) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
        end
        m_ready = '0;
        if (g >= 0) m_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            amt = (a >> (3 * g)) & 7;
            k = l[g] ? (8 - amt) % 8 : amt;
            m_data = rot_ref((d >> (8 * g)) & 255, k);
            m_id = g; m_amt = k; m_valid = 1; m_ptr = (g + 1) % N;
        end else if (orr) begin
            m_valid = 0;
        end
    endtask

    task automatic check_model(input string tag, input logic [3:0] seen);
        checkOutput({tag, "_ready"}, seen,      m_ready);
        checkOutput({tag, "_valid"}, out_valid, m_valid);
        checkOutput({tag, "_data"},  out_data,  m_data);
        checkOutput({tag, "_id"},    out_id,    m_id);
        checkOutput({tag, "_amt"},   out_amt,   m_amt);
    endtask

    initial begin
        logic [3:0] seen;
        logic [3:0] rv, rl;
        logic [31:0] rd;
        logic [11:0] ra;

        vecs[0]  = '{4'b0001, 32'h0000_00FE, 12'h001, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'h7F, 2'd0, 3'd1};
        vecs[1]  = '{4'b0000, 32'h0,         12'h000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h7F, 2'd0, 3'd1};
        vecs[2]  = '{4'b0100, 32'h0081_0000, 12'h040, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h03, 2'd2, 3'd7};
        vecs[3]  = '{4'b0100, 32'h0081_0000, 12'h000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h81, 2'd2, 3'd0};
        vecs[4]  = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b1, 4'b1000, 1'b1, 8'h11, 2'd3, 3'd0};
        vecs[5]  = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'h44, 2'd0, 3'd0};
        vecs[6]  = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h33, 2'd1, 3'd0};
        vecs[7]  = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2, 3'd0};
        vecs[8]  = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b1, 4'b1000, 1'b1, 8'h11, 2'd3, 3'd0};
        vecs[9]  = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'h44, 2'd0, 3'd0};
        vecs[10] = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h33, 2'd1, 3'd0};
        vecs[11] = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd1, 3'd0};
        vecs[12] = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd1, 3'd0};
        vecs[13] = '{4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd1, 3'd0};
        vecs[14] = '{4'b0010, 32'h0000_5A00, 12'h010, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h96, 2'd1, 3'd2};
        vecs[15] = '{4'b1000, 32'hF000_0000, 12'h600, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'h87, 2'd3, 3'd5};
        vecs[16] = '{4'b1010, 32'hF000_5A00, 12'h610, 4'b1000, 1'b1, 4'b0010, 1'b1, 8'h96, 2'd1, 3'd2};
        vecs[17] = '{4'b1010, 32'hF000_5A00, 12'h610, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'h87, 2'd3, 3'd5};
        vecs[18] = '{4'b0000, 32'h0,         12'h000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h87, 2'd3, 3'd5};

        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_amt = '0; req_left = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_data",  out_data,  0);
        checkOutput("reset_id",    out_id,    0);
        checkOutput("reset_amt",   out_amt,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].amt, vecs[i].left,
                          vecs[i].oready, seen);
            checkOutput($sformatf("vec%0d_ready", i), seen,      vecs[i].exp_ready);
            checkOutput($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d_data", i),  out_data,  vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_id", i),    out_id,    vecs[i].exp_id);
            checkOutput($sformatf("vec%0d_amt", i),   out_amt,   vecs[i].exp_amt);
        end

        // Load a result, then reset asynchronously mid-cycle.
        applyStimulus(4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b0, seen);
        checkOutput("preload_valid", out_valid, 1);
        checkOutput("preload_data",  out_data,  8'h44);
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", out_valid, 0);
        checkOutput("async_data",  out_data,  0);
        checkOutput("async_id",    out_id,    0);
        checkOutput("async_amt",   out_amt,   0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(4'b1111, 32'h1122_3344, 12'h000, 4'b0000, 1'b1, seen);
        checkOutput("post_rst_ready", seen,   4'b0001);
        checkOutput("post_rst_id",    out_id, 0);
        checkOutput("post_rst_data",  out_data, 8'h44);

        for (int c = 0; c < 400; c++) begin
            rv = 4'($urandom_range(0, 15));
            rd = $urandom;
            ra = 12'($urandom_range(0, 4095));
            rl = 4'($urandom_range(0, 15));
            applyStimulus(rv, rd, ra, rl, $urandom_range(0, 3) != 0, seen);
            check_model($sformatf("rand%0d", c), seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
